// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS 8b/10b encoder.
//   SYM_W    : width of one TMDS symbol
//   DISP_W   : width of the running disparity / per-symbol diff (two's complement)
//   TOKEN_xx : control tokens sent during blanking, indexed by {C1, C0}
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DISP_W = 5;

  localparam logic [SYM_W-1:0] TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctl_token(input logic [1:0] c);
    logic [SYM_W-1:0] t;
    case (c)
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      2'b11:   t = TOKEN_11;
      default: t = TOKEN_00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_ch.sv
// One TMDS 8b/10b channel, two registered stages.
//   Stage 1: transition-minimising q_m[8:0], its disparity diff, DE and control.
//   Stage 2: DC-balancing against the running disparity cnt, registered symbol.
// Ports:
//   pxl_clk : pixel clock
//   rst     : asynchronous active-high reset
//   de      : data enable
//   ctl     : control bits {C1, C0} used during blanking
//   data    : pixel byte
//   sym     : 10-bit symbol, bit 0 first on the wire
module tmds_encoder_ch
  import tmds_pkg::*;
(
  input  logic             pxl_clk,
  input  logic             rst,
  input  logic             de,
  input  logic [1:0]       ctl,
  input  logic [7:0]       data,
  output logic [SYM_W-1:0] sym
);

  logic [3:0]        n1_d;
  logic              xnor_mode;
  logic [8:0]        qm_d;
  logic [DISP_W-1:0] diff_d;

  logic              de_q;
  logic [1:0]        ctl_q;
  logic [8:0]        qm_q;
  logic [DISP_W-1:0] diff_q;
  logic [DISP_W-1:0] cnt;

  logic [SYM_W-1:0]  sym_d;
  logic [DISP_W-1:0] cnt_d;
  logic [DISP_W-1:0] two_qm8;
  logic [DISP_W-1:0] two_nqm8;

  always_comb begin
    n1_d      = popcount8(data);
    xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    qm_d      = '0;
    qm_d[0]   = data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = xnor_mode ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    qm_d[8]   = ~xnor_mode;
    // n1 - n0 over 8 bits equals 2*n1 - 8; modulo-32 arithmetic yields the signed value.
    diff_d    = {popcount8(qm_d[7:0]), 1'b0} - DISP_W'(8);
  end

  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      de_q   <= 1'b0;
      ctl_q  <= 2'b00;
      qm_q   <= '0;
      diff_q <= '0;
    end else begin
      de_q   <= de;
      ctl_q  <= ctl;
      qm_q   <= qm_d;
      diff_q <= diff_d;
    end
  end

  always_comb begin
    sym_d    = TOKEN_00;
    cnt_d    = cnt;
    two_qm8  = {3'b000, qm_q[8], 1'b0};
    two_nqm8 = {3'b000, ~qm_q[8], 1'b0};
    if (!de_q) begin
      sym_d = ctl_token(ctl_q);
      cnt_d = '0;
    end else if ((cnt == '0) || (diff_q == '0)) begin
      sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt + diff_q) : (cnt - diff_q);
    end else if (cnt[DISP_W-1] == diff_q[DISP_W-1]) begin
      // Both non-zero with equal sign: invert to pull disparity back toward zero.
      sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt + two_qm8 - diff_q;
    end else begin
      sym_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt - two_nqm8 + diff_q;
    end
  end

  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      sym <= TOKEN_00;
      cnt <= '0;
    end else begin
      sym <= sym_d;
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI TMDS encoder; 2-clock latency from inputs to symbols.
// Ports:
//   I_pxl_clk                  : pixel clock
//   I_rst                      : asynchronous active-high reset
//   I_rgb_de/hs/vs             : data enable and syncs (syncs already at final polarity)
//   I_rgb_r/g/b                : 8-bit pixel components
//   O_tmds_r/g/b               : 10-bit symbols to the serializers, bit 0 first
// Blue carries HS/VS as C0/C1; green and red send control 00 during blanking.
module tmds_encoder_rgb
  import tmds_pkg::*;
(
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic             I_rgb_de,
  input  logic             I_rgb_hs,
  input  logic             I_rgb_vs,
  input  logic [7:0]       I_rgb_r,
  input  logic [7:0]       I_rgb_g,
  input  logic [7:0]       I_rgb_b,
  output logic [SYM_W-1:0] O_tmds_r,
  output logic [SYM_W-1:0] O_tmds_g,
  output logic [SYM_W-1:0] O_tmds_b
);

  tmds_encoder_ch u_ch_b (
    .pxl_clk (I_pxl_clk),
    .rst     (I_rst),
    .de      (I_rgb_de),
    .ctl     ({I_rgb_vs, I_rgb_hs}),
    .data    (I_rgb_b),
    .sym     (O_tmds_b)
  );

  tmds_encoder_ch u_ch_g (
    .pxl_clk (I_pxl_clk),
    .rst     (I_rst),
    .de      (I_rgb_de),
    .ctl     (2'b00),
    .data    (I_rgb_g),
    .sym     (O_tmds_g)
  );

  tmds_encoder_ch u_ch_r (
    .pxl_clk (I_pxl_clk),
    .rst     (I_rst),
    .de      (I_rgb_de),
    .ctl     (2'b00),
    .data    (I_rgb_r),
    .sym     (O_tmds_r)
  );

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
module tb_tmds_encoder_rgb;

  logic       I_pxl_clk;
  logic       I_rst;
  logic       I_rgb_de;
  logic       I_rgb_hs;
  logic       I_rgb_vs;
  logic [7:0] I_rgb_r;
  logic [7:0] I_rgb_g;
  logic [7:0] I_rgb_b;
  logic [9:0] O_tmds_r;
  logic [9:0] O_tmds_g;
  logic [9:0] O_tmds_b;

  tmds_encoder_rgb dut (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_rgb_de  (I_rgb_de),
    .I_rgb_hs  (I_rgb_hs),
    .I_rgb_vs  (I_rgb_vs),
    .I_rgb_r   (I_rgb_r),
    .I_rgb_g   (I_rgb_g),
    .I_rgb_b   (I_rgb_b),
    .O_tmds_r  (O_tmds_r),
    .O_tmds_g  (O_tmds_g),
    .O_tmds_b  (O_tmds_b)
  );

  initial I_pxl_clk = 1'b0;
  always #5 I_pxl_clk = ~I_pxl_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] er;
    logic [9:0] eg;
    logic [9:0] eb;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  typedef struct {
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] er;
    logic [9:0] eg;
    logic [9:0] eb;
  } exp_t;

  exp_t exp_q [$];
  int   cnt_m [3];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 10'h%03h, expected 10'h%03h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [9:0] er, input logic [9:0] eg,
                           input logic [9:0] eb);
    check({name, "_r"}, O_tmds_r, er);
    check({name, "_g"}, O_tmds_g, eg);
    check({name, "_b"}, O_tmds_b, eb);
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    I_rgb_de = de;
    I_rgb_hs = hs;
    I_rgb_vs = vs;
    I_rgb_r  = r;
    I_rgb_g  = g;
    I_rgb_b  = b;
  endtask

  task automatic tick();
    @(posedge I_pxl_clk);
    #1;
  endtask

  // Reference encoder working in plain integers, one call per pixel in order.
  function automatic logic [9:0] ref_enc(input int ch, input logic de, input logic [1:0] c,
                                         input logic [7:0] d);
    int         n1;
    int         ones;
    int         diff;
    logic       xm;
    logic [8:0] qm;
    logic [9:0] o;
    if (!de) begin
      cnt_m[ch] = 0;
      case (c)
        2'b00:   o = 10'b1101010100;
        2'b01:   o = 10'b0010101011;
        2'b10:   o = 10'b0101010100;
        default: o = 10'b1010101011;
      endcase
      return o;
    end
    n1 = $countones(d);
    xm = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xm ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xm;
    ones = $countones(qm[7:0]);
    diff = 2 * ones - 8;
    if (cnt_m[ch] == 0 || diff == 0) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_m[ch] = qm[8] ? cnt_m[ch] + diff : cnt_m[ch] - diff;
    end else if ((cnt_m[ch] > 0 && diff > 0) || (cnt_m[ch] < 0 && diff < 0)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      cnt_m[ch] = cnt_m[ch] + (qm[8] ? 2 : 0) - diff;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      cnt_m[ch] = cnt_m[ch] - (qm[8] ? 0 : 2) + diff;
    end
    return o;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic check_cnt_range();
    int cr;
    int cg;
    int cb;
    cr = int'($signed(dut.u_ch_r.cnt));
    cg = int'($signed(dut.u_ch_g.cnt));
    cb = int'($signed(dut.u_ch_b.cnt));
    n_checks++;
    if (cr > 10 || cr < -10 || cg > 10 || cg < -10 || cb > 10 || cb < -10) begin
      n_fail++;
      $display("FAIL cnt_range: got r=%0d g=%0d b=%0d, expected |cnt|<=10 at t=%0t",
               cr, cg, cb, $time);
    end
  endtask

  initial begin
    exp_t e;
    exp_t e2;
    logic de_r;
    int   run;
    logic hs_r;
    logic vs_r;
    logic [7:0] rr;
    logic [7:0] gg;
    logic [7:0] bb;

    //          de    hs    vs    r      g      b      exp_r    exp_g    exp_b
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h0AB};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h154};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h2AB};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 10'h100, 10'h200, 10'h100};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 10'h0FF, 10'h0FF, 10'h3FF};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 10'h0FF, 10'h3FF, 10'h100};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 10'h1F0, 10'h3FF, 10'h1F0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};

    I_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check_all("reset_hold", 10'h354, 10'h354, 10'h354);

    for (int i = 0; i <= NV; i++) begin
      if (i == 0) I_rst = 1'b0;
      if (i < NV) drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
      else        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      tick();
      if (i >= 1) check_all($sformatf("vec%0d", i - 1), vecs[i-1].er, vecs[i-1].eg, vecs[i-1].eb);
    end

    // Async reset in the middle of an active line, between clock edges.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    tick();
    #3;
    I_rst = 1'b1;
    #1;
    check_all("async_rst", 10'h354, 10'h354, 10'h354);
    @(posedge I_pxl_clk);
    #1;
    I_rst = 1'b0;
    tick();
    check_all("post_rst_pipe", 10'h354, 10'h354, 10'h354);
    tick();
    check_all("post_rst_first", 10'h100, 10'h100, 10'h100);

    // Settle into blanking so DUT and model both start from cnt = 0.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    cnt_m[2] = 0;

    de_r = 1'b0;
    run  = 0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        de_r = ~de_r;
        run  = $urandom_range(1, 40);
      end
      run--;
      hs_r = 1'($urandom_range(0, 1));
      vs_r = 1'($urandom_range(0, 1));
      rr   = 8'($urandom);
      gg   = 8'($urandom);
      bb   = 8'($urandom);
      drive(de_r, hs_r, vs_r, rr, gg, bb);
      e.de = de_r;
      e.r  = rr;
      e.g  = gg;
      e.b  = bb;
      e.er = ref_enc(0, de_r, 2'b00, rr);
      e.eg = ref_enc(1, de_r, 2'b00, gg);
      e.eb = ref_enc(2, de_r, {vs_r, hs_r}, bb);
      exp_q.push_back(e);
      tick();
      check_cnt_range();
      if (exp_q.size() == 2) begin
        e2 = exp_q.pop_front();
        check_all("rand", e2.er, e2.eg, e2.eb);
        if (e2.de) begin
          check("decode_r", {2'b00, decode(O_tmds_r)}, {2'b00, e2.r});
          check("decode_g", {2'b00, decode(O_tmds_g)}, {2'b00, e2.g});
          check("decode_b", {2'b00, decode(O_tmds_b)}, {2'b00, e2.b});
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
